// File: rtl/interp_scheduler_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : interp_scheduler_pkg
//  Description : Shared types and default widths for the centroid->point
//                interpolator scheduler.
//  Contents    : sched_state_t  - scheduler FSM states
//                centroid_t     - {x,y,z} centroid at default widths
//                c_* defaults   - widths, FIFO depth, walk timeout
//  Revision    : 1.0 - initial release
// ============================================================================
package interp_scheduler_pkg;

  localparam int c_X_WIDTH     = 9;
  localparam int c_Y_WIDTH     = 8;
  localparam int c_Z_WIDTH     = 9;
  localparam int c_FIFO_DEPTH  = 4;
  localparam int c_TIMEOUT_CYC = 1023;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRIME = 2'd1,
    ARM   = 2'd2,
    RUN   = 2'd3
  } sched_state_t;

  typedef struct packed {
    logic [c_X_WIDTH-1:0] x;
    logic [c_Y_WIDTH-1:0] y;
    logic [c_Z_WIDTH-1:0] z;
  } centroid_t;

endpackage
`default_nettype wire

// File: rtl/interp_scheduler_if.sv
`default_nettype none
// ============================================================================
//  Module      : interp_scheduler_if
//  Description : Bundle of the scheduler's centroid input, interpolator
//                control and status signals.
//  Ports       : in_x/in_y/in_z/in_valid/in_ready - centroid push handshake
//                cen_x/cen_y/cen_z/cen_ready      - load to interpolator
//                interp_rst/interp_done           - interpolator control
//                point_valid/busy/fifo_count/timeout_err - status
//  Modports    : master - environment (centroid source + interpolator)
//                slave  - the scheduler
//  Revision    : 1.0 - initial release
// ============================================================================
interface interp_scheduler_if #(
  parameter int X_WIDTH    = 9,
  parameter int Y_WIDTH    = 8,
  parameter int Z_WIDTH    = 9,
  parameter int FIFO_DEPTH = 4
);
  logic [X_WIDTH-1:0]            in_x;
  logic [Y_WIDTH-1:0]            in_y;
  logic [Z_WIDTH-1:0]            in_z;
  logic                          in_valid;
  logic                          in_ready;
  logic [X_WIDTH-1:0]            cen_x;
  logic [Y_WIDTH-1:0]            cen_y;
  logic [Z_WIDTH-1:0]            cen_z;
  logic                          cen_ready;
  logic                          interp_rst;
  logic                          interp_done;
  logic                          point_valid;
  logic                          busy;
  logic [$clog2(FIFO_DEPTH):0]   fifo_count;
  logic                          timeout_err;

  modport master (
    output in_x, in_y, in_z, in_valid, interp_done,
    input  in_ready, cen_x, cen_y, cen_z, cen_ready, interp_rst,
           point_valid, busy, fifo_count, timeout_err
  );

  modport slave (
    input  in_x, in_y, in_z, in_valid, interp_done,
    output in_ready, cen_x, cen_y, cen_z, cen_ready, interp_rst,
           point_valid, busy, fifo_count, timeout_err
  );
endinterface
`default_nettype wire

// File: rtl/interp_scheduler_centroid_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : interp_scheduler_centroid_fifo
//  Description : Small synchronous FIFO of centroids. Pointers carry one
//                extra wrap bit so full and empty are distinguishable.
//  Ports       : clk_in, rst_n_in (sync, active-low: flushes pointers)
//                i_push/i_data/o_full - write side (push ignored when full)
//                i_pop/o_head         - read side (head visible while !empty)
//                o_count              - entries held
//  Revision    : 1.0 - initial release
// ============================================================================
module interp_scheduler_centroid_fifo
  import interp_scheduler_pkg::*;
#(
  parameter int  DEPTH   = 4,
  parameter type ENTRY_T = centroid_t
) (
  input  logic                   clk_in,
  input  logic                   rst_n_in,
  input  logic                   i_push,
  input  ENTRY_T                 i_data,
  output logic                   o_full,
  input  logic                   i_pop,
  output ENTRY_T                 o_head,
  output logic [$clog2(DEPTH):0] o_count
);
  localparam int AW = $clog2(DEPTH);

  ENTRY_T        r_mem [DEPTH];
  logic [AW:0]   r_wptr;
  logic [AW:0]   r_rptr;
  logic          w_do_push;
  logic          w_do_pop;

  assign o_count   = r_wptr - r_rptr;
  // Same slot index with differing wrap bits means the writer lapped the reader.
  assign o_full    = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign o_head    = r_mem[r_rptr[AW-1:0]];
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && (o_count != '0);

  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + 1'b1;
      if (w_do_pop)  r_rptr <= r_rptr + 1'b1;
    end
  end

  // Storage needs no reset; emptiness is defined by the pointers alone.
  always_ff @(posedge clk_in) begin
    if (w_do_push) r_mem[r_wptr[AW-1:0]] <= i_data;
  end
endmodule
`default_nettype wire

// File: rtl/interp_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : interp_scheduler
//  Description : Sequences the centroid->point interpolator. Buffers
//                centroids, loads one at a time (held stable for the whole
//                walk), qualifies stepped points, aborts hung walks.
//  Ports       : clk_in   - system clock
//                rst_n_in - synchronous reset, active-low
//                bus      - interp_scheduler_if.slave (centroid input,
//                           interpolator load/reset/done, status outputs)
//  Revision    : 1.0 - initial release
// ============================================================================
module interp_scheduler
  import interp_scheduler_pkg::*;
#(
  parameter int X_WIDTH     = c_X_WIDTH,
  parameter int Y_WIDTH     = c_Y_WIDTH,
  parameter int Z_WIDTH     = c_Z_WIDTH,
  parameter int FIFO_DEPTH  = c_FIFO_DEPTH,
  parameter int TIMEOUT_CYC = c_TIMEOUT_CYC
) (
  input  logic              clk_in,
  input  logic              rst_n_in,
  interp_scheduler_if.slave bus
);
  typedef struct packed {
    logic [X_WIDTH-1:0] x;
    logic [Y_WIDTH-1:0] y;
    logic [Z_WIDTH-1:0] z;
  } cen_t;

  localparam int             TW      = $clog2(TIMEOUT_CYC + 1);
  localparam int             CW      = $clog2(FIFO_DEPTH) + 1;
  localparam logic [TW-1:0]  c_TLAST = TW'(TIMEOUT_CYC - 1);

  sched_state_t  r_state, w_state_nxt;
  logic          r_primed, w_primed_nxt;
  cen_t          r_cen, w_cen_nxt;
  logic          r_cen_ready, w_cen_ready_nxt;
  logic          r_interp_rst, w_interp_rst_nxt;
  logic          r_timeout_err, w_timeout_err_nxt;
  logic [TW-1:0] r_tcnt, w_tcnt_nxt;

  cen_t          w_in;
  cen_t          w_head;
  logic          w_full;
  logic          w_pop;
  logic [CW-1:0] w_count;

  assign w_in = {bus.in_x, bus.in_y, bus.in_z};

  interp_scheduler_centroid_fifo #(
    .DEPTH   (FIFO_DEPTH),
    .ENTRY_T (cen_t)
  ) u_fifo (
    .clk_in   (clk_in),
    .rst_n_in (rst_n_in),
    .i_push   (bus.in_valid),
    .i_data   (w_in),
    .o_full   (w_full),
    .i_pop    (w_pop),
    .o_head   (w_head),
    .o_count  (w_count)
  );

  always_comb begin
    w_state_nxt       = r_state;
    w_primed_nxt      = r_primed;
    w_cen_nxt         = r_cen;
    w_cen_ready_nxt   = 1'b0;
    w_interp_rst_nxt  = 1'b0;
    w_timeout_err_nxt = r_timeout_err;
    w_tcnt_nxt        = r_tcnt;
    w_pop             = 1'b0;
    case (r_state)
      IDLE: begin
        // Loading is held off while the interpolator is still in reset.
        if (w_count != '0 && !r_interp_rst) begin
          w_pop           = 1'b1;
          w_cen_nxt       = w_head;
          w_cen_ready_nxt = 1'b1;
          w_state_nxt     = r_primed ? ARM : PRIME;
        end
      end
      PRIME: begin
        // First load after reset only sets the interpolator's start point.
        w_primed_nxt = 1'b1;
        w_state_nxt  = IDLE;
      end
      ARM: begin
        // interp_done is still stale from the previous walk this cycle.
        w_tcnt_nxt  = '0;
        w_state_nxt = RUN;
      end
      RUN: begin
        if (bus.interp_done) begin
          w_state_nxt = IDLE;
        end else if (r_tcnt == c_TLAST) begin
          w_timeout_err_nxt = 1'b1;
          w_interp_rst_nxt  = 1'b1;
          w_primed_nxt      = 1'b0;
          w_state_nxt       = IDLE;
        end else begin
          w_tcnt_nxt = r_tcnt + 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      r_state       <= IDLE;
      r_primed      <= 1'b0;
      r_cen         <= '0;
      r_cen_ready   <= 1'b0;
      r_interp_rst  <= 1'b1;
      r_timeout_err <= 1'b0;
      r_tcnt        <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_primed      <= w_primed_nxt;
      r_cen         <= w_cen_nxt;
      r_cen_ready   <= w_cen_ready_nxt;
      r_interp_rst  <= w_interp_rst_nxt;
      r_timeout_err <= w_timeout_err_nxt;
      r_tcnt        <= w_tcnt_nxt;
    end
  end

  assign bus.in_ready    = !w_full;
  assign bus.cen_x       = r_cen.x;
  assign bus.cen_y       = r_cen.y;
  assign bus.cen_z       = r_cen.z;
  assign bus.cen_ready   = r_cen_ready;
  assign bus.interp_rst  = r_interp_rst;
  assign bus.point_valid = (r_state == RUN) && !bus.interp_done;
  assign bus.busy        = (r_state != IDLE);
  assign bus.fifo_count  = w_count;
  assign bus.timeout_err = r_timeout_err;
endmodule
`default_nettype wire

// File: tb/tb_interp_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_interp_scheduler
//  Description : Testbench for interp_scheduler, paired with a behavioural
//                interpolator. Expected outputs come from a per-cycle
//                timeline derived from walk lengths (Chebyshev distance).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_interp_scheduler;
  import interp_scheduler_pkg::*;

  localparam int DEPTH = 4;
  localparam int TO    = 1023;

  typedef struct packed {
    logic      busy;
    logic      pv;
    logic      cr;
    logic      irst;
    centroid_t pt;
  } cyc_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic stuck = 1'b0;
  always #5 clk = ~clk;

  interp_scheduler_if ifc ();

  interp_scheduler dut (
    .clk_in   (clk),
    .rst_n_in (rst_n),
    .bus      (ifc)
  );

  int n_checks = 0;
  int n_err    = 0;

  function automatic void chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endfunction

  function automatic centroid_t step_to(input centroid_t p, input centroid_t t);
    centroid_t r = p;
    if (p.x < t.x) r.x = p.x + 1'b1; else if (p.x > t.x) r.x = p.x - 1'b1;
    if (p.y < t.y) r.y = p.y + 1'b1; else if (p.y > t.y) r.y = p.y - 1'b1;
    if (p.z < t.z) r.z = p.z + 1'b1; else if (p.z > t.z) r.z = p.z - 1'b1;
    return r;
  endfunction

  function automatic int absdiff(input int a, input int b);
    return (a > b) ? a - b : b - a;
  endfunction

  function automatic int cheb(input centroid_t a, input centroid_t b);
    int m = absdiff(int'(a.x), int'(b.x));
    if (absdiff(int'(a.y), int'(b.y)) > m) m = absdiff(int'(a.y), int'(b.y));
    if (absdiff(int'(a.z), int'(b.z)) > m) m = absdiff(int'(a.z), int'(b.z));
    return m;
  endfunction

  function automatic cyc_t mk(input logic b, input logic v, input logic c,
                              input logic r, input centroid_t p);
    cyc_t e;
    e.busy = b; e.pv = v; e.cr = c; e.irst = r; e.pt = p;
    return e;
  endfunction

  // ---------------- behavioural interpolator ----------------
  centroid_t im_p       = '0;
  logic      im_done    = 1'b1;
  logic      im_started = 1'b0;
  centroid_t live_cen;
  assign live_cen        = {ifc.cen_x, ifc.cen_y, ifc.cen_z};
  assign ifc.interp_done = stuck ? 1'b0 : im_done;

  always @(posedge clk) begin
    if (ifc.interp_rst) begin
      im_p       <= '0;
      im_done    <= 1'b1;
      im_started <= 1'b0;
    end else if (ifc.cen_ready) begin
      if (!im_started) begin
        im_p       <= live_cen;
        im_started <= 1'b1;
        im_done    <= 1'b1;
      end else begin
        im_done <= 1'b0;
      end
    end else if (!im_done) begin
      if (im_p == live_cen) im_done <= 1'b1;
      else                  im_p    <= step_to(im_p, live_cen);
    end
  end

  // ---------------- reference timeline model ----------------
  centroid_t mq[$];
  cyc_t      plan[$];
  cyc_t      cur;
  centroid_t m_cen, m_ipos, m_c, m_p;
  logic      m_primed, m_terr, m_ok = 1'b0;
  logic      m_pop, m_push;
  int        m_n;

  always @(posedge clk) begin
    if (!rst_n) begin
      mq.delete();
      plan.delete();
      cur      = mk(1'b0, 1'b0, 1'b0, 1'b1, '0);
      m_cen    = '0;
      m_ipos   = '0;
      m_primed = 1'b0;
      m_terr   = 1'b0;
      m_ok     = 1'b1;
    end else if (m_ok) begin
      m_pop  = !cur.busy && !cur.irst && (mq.size() > 0);
      m_push = ifc.in_valid && (mq.size() < DEPTH);
      if (m_pop) begin
        m_c   = mq.pop_front();
        m_cen = m_c;
        plan.push_back(mk(1'b1, 1'b0, 1'b1, 1'b0, '0));
        if (!m_primed) begin
          m_primed = 1'b1;
          m_ipos   = m_c;
        end else begin
          m_n = cheb(m_ipos, m_c);
          m_p = m_ipos;
          if (stuck) begin
            for (int i = 0; i < TO; i++) begin
              plan.push_back(mk(1'b1, 1'b1, 1'b0, 1'b0, m_p));
              m_p = step_to(m_p, m_c);
            end
            plan.push_back(mk(1'b0, 1'b0, 1'b0, 1'b1, '0));
            m_primed = 1'b0;
          end else begin
            for (int i = 0; i <= m_n; i++) begin
              plan.push_back(mk(1'b1, 1'b1, 1'b0, 1'b0, m_p));
              m_p = step_to(m_p, m_c);
            end
            plan.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, '0));
            m_ipos = m_c;
          end
        end
      end
      if (m_push) mq.push_back({ifc.in_x, ifc.in_y, ifc.in_z});
      if (plan.size() > 0) cur = plan.pop_front();
      else                 cur = mk(1'b0, 1'b0, 1'b0, 1'b0, '0);
      if (cur.irst) m_terr = 1'b1;
    end
  end

  // ---------------- compare + monitors ----------------
  int        pv_cnt = 0, cr_cnt = 0, irst_cnt = 0;
  logic      saw_full = 1'b0;
  centroid_t pts[$];

  always @(negedge clk) begin
    if (m_ok) begin
      chk("busy",        int'(ifc.busy),        int'(cur.busy));
      chk("point_valid", int'(ifc.point_valid), int'(cur.pv));
      chk("cen_ready",   int'(ifc.cen_ready),   int'(cur.cr));
      chk("interp_rst",  int'(ifc.interp_rst),  int'(cur.irst));
      chk("timeout_err", int'(ifc.timeout_err), int'(m_terr));
      chk("fifo_count",  int'(ifc.fifo_count),  mq.size());
      chk("in_ready",    int'(ifc.in_ready),    int'(mq.size() < DEPTH));
      chk("cen",         int'(live_cen),        int'(m_cen));
      if (cur.pv) chk("point", int'(im_p), int'(cur.pt));
      if (ifc.point_valid) begin
        pv_cnt++;
        pts.push_back(im_p);
      end
      if (ifc.cen_ready)  cr_cnt++;
      if (ifc.interp_rst) irst_cnt++;
      if (int'(ifc.fifo_count) == DEPTH && !ifc.in_ready) saw_full = 1'b1;
    end
  end

  // ---------------- stimulus ----------------
  task automatic push(input int x, input int y, input int z);
    int n = 0;
    ifc.in_x     = 9'(x);
    ifc.in_y     = 8'(y);
    ifc.in_z     = 9'(z);
    ifc.in_valid = 1'b1;
    while (!ifc.in_ready && n < 4000) begin
      @(negedge clk);
      n++;
    end
    chk("push_accept", int'(ifc.in_ready), 1);
    @(negedge clk);
    ifc.in_valid = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((ifc.busy || ifc.fifo_count != '0) && n < budget);
    chk("drain", int'(ifc.busy || ifc.fifo_count != '0), 0);
    repeat (3) @(negedge clk);
  endtask

  task automatic clear_mon();
    pv_cnt   = 0;
    cr_cnt   = 0;
    irst_cnt = 0;
    saw_full = 1'b0;
    pts.delete();
  endtask

  centroid_t exp_pts[4];

  initial begin
    ifc.in_valid = 1'b0;
    ifc.in_x     = '0;
    ifc.in_y     = '0;
    ifc.in_z     = '0;

    // Reset state
    @(negedge clk);
    chk("rst_interp_rst", int'(ifc.interp_rst),  1);
    chk("rst_busy",       int'(ifc.busy),        0);
    chk("rst_fifo_count", int'(ifc.fifo_count),  0);
    chk("rst_cen_ready",  int'(ifc.cen_ready),   0);
    chk("rst_timeout",    int'(ifc.timeout_err), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // 1: first centroid only primes
    clear_mon();
    push(10, 10, 10);
    wait_idle(100);
    chk("t1_cen_ready_pulses", cr_cnt, 1);
    chk("t1_point_valid",      pv_cnt, 0);

    // 2: 3-step walk, start point plus 3 steps
    clear_mon();
    push(13, 12, 10);
    wait_idle(100);
    exp_pts[0] = {9'd10, 8'd10, 9'd10};
    exp_pts[1] = {9'd11, 8'd11, 9'd10};
    exp_pts[2] = {9'd12, 8'd12, 9'd10};
    exp_pts[3] = {9'd13, 8'd12, 9'd10};
    chk("t2_pv_cycles", pv_cnt, 4);
    for (int i = 0; i < 4; i++)
      chk("t2_point", (i < pts.size()) ? int'(pts[i]) : -1, int'(exp_pts[i]));

    // 3: five back-to-back pushes fill the FIFO
    clear_mon();
    push(400, 200, 0);
    push(0, 0, 300);
    push(100, 250, 50);
    push(500, 10, 400);
    push(5, 5, 5);
    wait_idle(6000);
    chk("t3_saw_full",   int'(saw_full), 1);
    chk("t3_walks",      cr_cnt, 5);
    chk("t3_fifo_empty", int'(ifc.fifo_count), 0);

    // 4: duplicate centroid gives exactly one point
    clear_mon();
    push(13, 12, 10);
    wait_idle(200);
    chk("t4_first_pv", pv_cnt, 9);
    clear_mon();
    push(13, 12, 10);
    wait_idle(200);
    chk("t4_dup_pv", pv_cnt, 1);

    // 5: hung walk times out, next centroid re-primes
    stuck = 1'b1;
    clear_mon();
    push(20, 20, 20);
    wait_idle(3000);
    stuck = 1'b0;
    chk("t5_timeout_err", int'(ifc.timeout_err), 1);
    chk("t5_pv_cycles",   pv_cnt, TO);
    chk("t5_irst_pulse",  irst_cnt, 1);
    clear_mon();
    push(30, 30, 30);
    wait_idle(200);
    chk("t5_reprime_cr", cr_cnt, 1);
    chk("t5_reprime_pv", pv_cnt, 0);
    clear_mon();
    push(31, 30, 30);
    wait_idle(200);
    chk("t5_walk_after", pv_cnt, 2);

    // 6: reset mid-walk with two queued
    push(400, 250, 400);
    push(1, 2, 3);
    push(4, 5, 6);
    repeat (5) @(negedge clk);
    chk("t6_pre_busy", int'(ifc.busy), 1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("t6_fifo_count", int'(ifc.fifo_count),  0);
    chk("t6_interp_rst", int'(ifc.interp_rst),  1);
    chk("t6_busy",       int'(ifc.busy),        0);
    chk("t6_cen",        int'(live_cen),        0);
    chk("t6_timeout",    int'(ifc.timeout_err), 0);
    chk("t6_pv",         int'(ifc.point_valid), 0);
    rst_n = 1'b1;

    // 7: randomized traffic against the model
    begin
      int rx = 0, ry = 0, rz = 0;
      for (int k = 0; k < 25; k++) begin
        if (k == 0 || $urandom_range(0, 4) != 0) begin
          rx = int'($urandom_range(0, 511));
          ry = int'($urandom_range(0, 255));
          rz = int'($urandom_range(0, 511));
        end
        push(rx, ry, rz);
        repeat ($urandom_range(0, 3)) @(negedge clk);
      end
    end
    wait_idle(20000);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule
`default_nettype wire
